// File: rtl/arb_mux.sv
// arb_mux: N-input registered mux with valid/ready handshakes; fixed-select or round-robin grant
module arb_mux #(
  parameter int WIDTH     = 32,
  parameter int SEL_WIDTH = 2,
  parameter int MODE      = 0
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [(2**SEL_WIDTH)*WIDTH-1:0]  in_data,
  input  logic [(2**SEL_WIDTH)-1:0]        in_valid,
  output logic [(2**SEL_WIDTH)-1:0]        in_ready,
  input  logic [SEL_WIDTH-1:0]             sel,
  output logic [WIDTH-1:0]                 out_data,
  output logic [SEL_WIDTH-1:0]             out_src,
  output logic                             out_valid,
  input  logic                             out_ready
);
  localparam int NUM_IN = 2**SEL_WIDTH;
  logic [NUM_IN-1:0][WIDTH-1:0] in_words;
  logic [SEL_WIDTH-1:0] last_grant, rr_grant, grant;
  logic grant_valid, load_en;
  assign in_words = in_data;
  assign load_en = !out_valid || out_ready;
  // Scan from farthest to nearest so the index right after last_grant wins; wrap is free at 2**SEL_WIDTH
  always_comb begin
    rr_grant = last_grant;
    for (int k = NUM_IN; k >= 1; k--)
      if (in_valid[last_grant + SEL_WIDTH'(k)]) rr_grant = last_grant + SEL_WIDTH'(k);
  end
  assign grant       = (MODE == 1) ? rr_grant : sel;
  assign grant_valid = (MODE == 1) ? |in_valid : in_valid[sel];
  assign in_ready    = (rst_n && load_en && grant_valid) ? NUM_IN'(1) << grant : '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_src    <= '0;
      last_grant <= '1;
    end else if (load_en) begin
      out_valid <= grant_valid;
      if (grant_valid) begin
        out_data <= in_words[grant];
        out_src  <= grant;
        if (MODE == 1) last_grant <= grant;
      end
    end
  end
endmodule

// File: tb/tb_arb_mux.sv
// tb_arb_mux: scoreboard bench driving a fixed-select and a round-robin instance of arb_mux
module tb_arb_mux;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n0 = 1'b0, rst_n1 = 1'b0;
  logic [127:0] in_data0 = {32'h44444444, 32'hDEADBEEF, 32'h22222222, 32'h11111111};
  logic [127:0] in_data1 = {32'hA0000003, 32'hA0000002, 32'hA0000001, 32'hA0000000};
  logic [3:0] in_valid0 = 4'b1111, in_valid1 = 4'b1111;
  logic [3:0] in_ready0, in_ready1;
  logic [1:0] sel0 = 2'd2, sel1 = 2'd0;
  logic [31:0] out_data0, out_data1;
  logic [1:0] out_src0, out_src1;
  logic out_valid0, out_valid1;
  logic out_ready0 = 1'b1, out_ready1 = 1'b1;
  int compared = 0, mismatched = 0;
  logic [33:0] q0[$], q1[$];

  arb_mux #(.WIDTH(32), .SEL_WIDTH(2), .MODE(0)) d0 (
    .clk(clk), .rst_n(rst_n0), .in_data(in_data0), .in_valid(in_valid0), .in_ready(in_ready0),
    .sel(sel0), .out_data(out_data0), .out_src(out_src0), .out_valid(out_valid0), .out_ready(out_ready0));
  arb_mux #(.WIDTH(32), .SEL_WIDTH(2), .MODE(1)) d1 (
    .clk(clk), .rst_n(rst_n1), .in_data(in_data1), .in_valid(in_valid1), .in_ready(in_ready1),
    .sel(sel1), .out_data(out_data1), .out_src(out_src1), .out_valid(out_valid1), .out_ready(out_ready1));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [33:0] e;
    if (out_valid0 && out_ready0) begin
      if (q0.size() == 0) chk("d0_unexpected_word", {out_src0, out_data0}, 34'h0);
      else begin
        e = q0.pop_front();
        chk("d0_out", {out_src0, out_data0}, e);
      end
    end
    if (out_valid1 && out_ready1) begin
      if (q1.size() == 0) chk("d1_unexpected_word", {out_src1, out_data1}, 34'h0);
      else begin
        e = q1.pop_front();
        chk("d1_out", {out_src1, out_data1}, e);
      end
    end
  end

  task automatic step0(input logic [1:0] s, input logic [3:0] v, input logic r, input int g);
    sel0 = s; in_valid0 = v; out_ready0 = r;
    #1;
    chk("d0_in_ready", in_ready0, g < 0 ? 64'd0 : 64'd1 << g);
    if (g >= 0) q0.push_back({2'(g), in_data0[g*32 +: 32]});
    @(posedge clk); #1;
  endtask

  task automatic step1(input logic [3:0] v, input logic r, input int g);
    in_valid1 = v; out_ready1 = r;
    #1;
    chk("d1_in_ready", in_ready1, g < 0 ? 64'd0 : 64'd1 << g);
    if (g >= 0) q1.push_back({2'(g), in_data1[g*32 +: 32]});
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid0", out_valid0, 0);
    chk("rst_out_data0", out_data0, 0);
    chk("rst_out_src0", out_src0, 0);
    chk("rst_in_ready0", in_ready0, 0);
    chk("rst_out_valid1", out_valid1, 0);
    chk("rst_in_ready1", in_ready1, 0);
    rst_n0 = 1'b1;
    step0(2'd2, 4'b1111, 1'b1, 2);
    step0(2'd2, 4'b1011, 1'b1, -1);
    chk("d0_drop_valid", out_valid0, 0);
    chk("d0_hold_data", out_data0, 32'hDEADBEEF);
    step0(2'd0, 4'b1011, 1'b0, 0);
    step0(2'd3, 4'b1011, 1'b0, -1);
    chk("d0_sel_change_data", out_data0, 32'h11111111);
    chk("d0_sel_change_src", out_src0, 0);
    step0(2'd1, 4'b0010, 1'b1, 1);
    step0(2'd1, 4'b0000, 1'b1, -1);
    chk("d0_idle_valid", out_valid0, 0);
    rst_n1 = 1'b1;
    for (int i = 0; i < 8; i++) step1(4'b1111, 1'b1, i % 4);
    for (int i = 0; i < 4; i++) step1(4'b1010, 1'b1, (i % 2) ? 3 : 1);
    for (int i = 0; i < 5; i++) begin
      step1(4'b1111, 1'b0, -1);
      chk("d1_stall_data", out_data1, 32'hA0000003);
      chk("d1_stall_src", out_src1, 3);
    end
    step1(4'b1111, 1'b1, 0);
    step1(4'b1111, 1'b1, 1);
    step1(4'b1111, 1'b1, 2);
    rst_n1 = 1'b0;
    void'(q1.pop_back());
    #1;
    chk("d1_midrst_valid", out_valid1, 0);
    chk("d1_midrst_ready", in_ready1, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("d1_midrst_hold", out_valid1, 0);
    rst_n1 = 1'b1;
    step1(4'b1111, 1'b1, 0);
    step1(4'b0000, 1'b1, -1);
    repeat (2) @(posedge clk);
    #1;
    chk("d0_queue_drained", q0.size(), 0);
    chk("d1_queue_drained", q1.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/arb_mux.md
# arb_mux

Parametrised N-input, registered multiplexer with valid/ready handshaking on every input and on the output. It selects one requesting input per cycle, either from an externally driven select (fixed mode) or by round-robin arbitration (arbitrated mode), and registers the chosen word into a one-entry output stage. It sits wherever several pipeline producers share one consumer, for example instruction-fetch and data-access requests contending for a single memory port.

## Interface
- `WIDTH`, 32, data width of each input and of the output, in bits.
- `SEL_WIDTH`, 2, select/index width; the number of inputs is NUM_IN = 2**SEL_WIDTH.
- `MODE`, 0, selection mode: 0 = external `sel`, 1 = round-robin.

- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst_n`  input  1  reset, asynchronous and active-low.
- `in_data`  input  NUM_IN*WIDTH  flattened inputs; input i occupies bits [i*WIDTH +: WIDTH].
- `in_valid`  input  NUM_IN  per-input request.
- `in_ready`  output  NUM_IN  per-input accept; at most one bit is high in any cycle.
- `sel`  input  SEL_WIDTH  input index used in MODE 0; ignored in MODE 1.
- `out_data`  output  WIDTH  registered selected word.
- `out_src`  output  SEL_WIDTH  index of the input that supplied `out_data`.
- `out_valid`  output  1  output register holds a word.
- `out_ready`  input  1  consumer accepts the word this cycle.

## Operation
- A transfer on a port occurs in a cycle where valid and ready are both high at the rising edge.
- `load_en = !out_valid || out_ready`: the output register can accept a new word when it is empty or is being drained in the same cycle.
- Grant selection is combinational and is evaluated every cycle.
  - MODE 0: grant = `sel`. `grant_valid` = `in_valid[sel]`. Other valid inputs are never granted, even when `in_valid[sel]`=0.
  - MODE 1: search starts at `last_grant+1` modulo NUM_IN, wrapping from NUM_IN-1 to 0. The first index with `in_valid` high is granted. `grant_valid` = |`in_valid`.
- `in_ready[i] = load_en && grant_valid && (grant == i)`. The value of `in_ready` never depends on `in_data`.
- Edge, when `load_en && grant_valid`:
  - `out_data` <= the granted slice.
  - `out_src` <= grant.
  - `out_valid` <= 1.
  - In MODE 1 only, `last_grant` <= grant.
- Edge, when `load_en && !grant_valid`: `out_valid` <= 0. `out_data` and `out_src` hold their values.
- Edge, when `!load_en` (stall): all registers hold, and `out_data`/`out_src` stay stable until the word is accepted.
- `last_grant` changes only when a transfer into the output register occurs; a stall never advances the round-robin pointer.
- Reset values (asserted asynchronously whenever `rst_n`=0):
  - `out_valid`=0, `out_data`=0, `out_src`=0.
  - `last_grant`=NUM_IN-1, so input 0 has first priority after reset.
  - `in_ready`=0, because `out_valid`=0 during reset forces `load_en`=1 but the inputs are gated.
  - While `rst_n`=0, `in_ready` is forced to 0.

## Timing
- Latency is 1 cycle: a word accepted at edge k is visible on `out_data` with `out_valid`=1 after edge k.
- Throughput is 1 word/cycle when `out_ready` is held high; no bubble is inserted on back-to-back transfers.
- The path from `out_ready` to `in_ready` is combinational (single registered stage, no skid buffer); the consumer must not derive `out_ready` combinationally from `in_ready`.
- Simultaneous output drain and new load in one cycle: the new word replaces the old one and `out_valid` stays 1.
- In MODE 0, a change of `sel` takes effect in the same cycle and does not disturb a word already held in the output register.
- Reset asserted mid-operation: the held word is discarded immediately (`out_valid` drops asynchronously). Release is synchronous to the first rising edge with `rst_n`=1, and the first grant then follows the priority from `last_grant`=NUM_IN-1.

## Test plan
- **Reset:** drive `rst_n`=0 with all `in_valid`=1 -> `out_valid`=0, `out_data`=0, `out_src`=0, `in_ready`=0; after release with input 0 valid, `out_src`=0 after the first edge.
- **MODE 0 select:** NUM_IN=4, `sel`=2, `in_data[2]`=0xDEADBEEF, `in_valid`=4'b1111, `out_ready`=1 -> after 1 edge `out_data`=0xDEADBEEF, `out_src`=2, and only `in_ready[2]`=1. Then `in_valid[2]`=0 -> `out_valid` falls to 0 while the other inputs stay ungranted.
- **MODE 1 fairness and wrap:** `in_valid`=4'b1111 held, `out_ready`=1 for 8 cycles -> `out_src` sequence 0,1,2,3,0,1,2,3.
- **MODE 1 sparse requests:** `in_valid`=4'b1010 held -> `out_src` sequence 1,3,1,3, with no bubble cycles.
- **Backpressure:** `out_ready`=0 for 5 cycles with a word loaded -> `out_data`/`out_src` stable, `in_ready`=0, and `last_grant` unchanged. Then `out_ready`=1 -> the next grant follows the held pointer.
- **Reset mid-stream:** MODE 1 streaming, `rst_n` pulsed low for 3 cycles while `last_grant`=2 -> `out_valid` drops during the pulse, and the first post-reset grant is input 0, not input 3.
